// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall and jump flush detection, plus registered
// forwarding selects for the EX stage from shadow EX/MEM/WB entries.
module pipe_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             jump,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } entry_t;

  // index 0 = EX, 1 = MEM, 2 = WB
  entry_t           r_stg [3];
  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_ex_prod, w_mem_prod, w_load_use, w_flush_idex;
  logic [1:0]       w_fwd_a, w_fwd_b;

  always_comb begin
    w_ex_prod    = r_stg[0].valid && r_stg[0].regwrite && r_stg[0].rd != 5'd0;
    w_mem_prod   = r_stg[1].valid && r_stg[1].regwrite && r_stg[1].rd != 5'd0;
    w_load_use   = id_valid && w_ex_prod && r_stg[0].memread &&
                   ((id_use_rs1 && id_rs1 == r_stg[0].rd) || (id_use_rs2 && id_rs2 == r_stg[0].rd));
    w_flush_idex = jump || w_load_use;
    w_fwd_a      = (id_use_rs1 && w_ex_prod && id_rs1 == r_stg[0].rd)  ? 2'b10 :
                   (id_use_rs1 && w_mem_prod && id_rs1 == r_stg[1].rd) ? 2'b01 : 2'b00;
    w_fwd_b      = (id_use_rs2 && w_ex_prod && id_rs2 == r_stg[0].rd)  ? 2'b10 :
                   (id_use_rs2 && w_mem_prod && id_rs2 == r_stg[1].rd) ? 2'b01 : 2'b00;
  end

  // rstn gating keeps the control outputs quiet during reset whatever the inputs
  assign stall      = rstn && w_load_use && !jump;
  assign flush_ifid = rstn && jump;
  assign flush_idex = rstn && w_flush_idex;
  assign ForwardA   = r_fwd_a;
  assign ForwardB   = r_fwd_b;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stg       <= '{default: '0};
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stg[0] <= w_flush_idex ? '0 : '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      r_stg[1] <= r_stg[0];
      r_stg[2] <= r_stg[1];
      r_fwd_a  <= w_flush_idex ? 2'b00 : w_fwd_a;
      r_fwd_b  <= w_flush_idex ? 2'b00 : w_fwd_b;
      if (stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (jump && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed hazard sequences with hand-computed expectations.
// Counters are narrowed to 4 bits so saturation is reachable in a few dozen cycles.
module tb_pipe_hazard_unit;
  localparam int CW     = 4;
  localparam int FW_RF  = 0;
  localparam int FW_MEM = 1;
  localparam int FW_EX  = 2;

  logic          clk, rstn;
  logic          id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, jump;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [1:0]    ForwardA, ForwardB;
  logic          stall, flush_ifid, flush_idex;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int            passed = 0;
  int            total = 0;

  pipe_hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .jump(jump),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a jump and a would-be reader present
    rstn = 1'b0;
    jump = 1'b1;
    set_id(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1);
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush_ifid", 32'(flush_ifid), 0);
    chk("rst_flush_idex", 32'(flush_idex), 0);
    chk("rst_fwda", 32'(ForwardA), FW_RF);
    chk("rst_fwdb", 32'(ForwardB), FW_RF);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    jump = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #10 rstn = 1'b1;
    tick();

    // back-to-back ALU: add x5 ; add x5 reading x5,x5 ; reader of x5 (EX and MEM both write x5)
    set_id(1, 0, 0, 0, 0, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0);
    #1 chk("alu_no_stall", 32'(stall), 0);
    tick();
    chk("alu_fwda_ex", 32'(ForwardA), FW_EX);
    chk("alu_fwdb_ex", 32'(ForwardB), FW_EX);
    set_id(1, 5'd5, 1, 0, 0, 5'd12, 1, 0);
    tick();
    chk("prio_fwda_ex", 32'(ForwardA), FW_EX);
    chk("prio_fwdb_rf", 32'(ForwardB), FW_RF);

    // distance 2: producer x7, independent, consumer rs2=x7
    set_id(1, 0, 0, 0, 0, 5'd7, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 5'd8, 1, 0);
    tick();
    set_id(1, 5'd1, 1, 5'd7, 1, 5'd10, 1, 0);
    #1 chk("d2_no_stall", 32'(stall), 0);
    tick();
    chk("d2_fwdb_mem", 32'(ForwardB), FW_MEM);
    chk("d2_fwda_rf", 32'(ForwardA), FW_RF);

    // load-use: lw x3 ; reader of x3 stalls one cycle, then forwards from MEM
    set_id(1, 0, 0, 0, 0, 5'd3, 1, 1);
    tick();
    set_id(1, 5'd3, 1, 0, 0, 5'd9, 1, 0);
    #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_flush_idex", 32'(flush_idex), 1);
    chk("lu_flush_ifid", 32'(flush_ifid), 0);
    tick();
    chk("lu_bubble_fwda", 32'(ForwardA), FW_RF);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_stall_once", 32'(stall), 0);
    chk("lu_flush_idex_once", 32'(flush_idex), 0);
    tick();
    chk("lu_fwda_mem", 32'(ForwardA), FW_MEM);
    chk("lu_stall_cnt_hold", 32'(stall_cnt), 1);

    // x0: load to x0 then readers of x0 never stall or forward
    set_id(1, 0, 0, 0, 0, 5'd0, 1, 1);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
    #1 chk("x0_no_stall", 32'(stall), 0);
    tick();
    chk("x0_fwda_ex", 32'(ForwardA), FW_RF);
    chk("x0_fwdb_ex", 32'(ForwardB), FW_RF);
    tick();
    chk("x0_fwda_mem", 32'(ForwardA), FW_RF);
    chk("x0_fwdb_mem", 32'(ForwardB), FW_RF);

    // jump together with load-use: jump wins
    set_id(1, 0, 0, 0, 0, 5'd4, 1, 1);
    tick();
    set_id(1, 5'd4, 1, 0, 0, 5'd11, 1, 0);
    jump = 1'b1;
    #1;
    chk("jmp_stall", 32'(stall), 0);
    chk("jmp_flush_ifid", 32'(flush_ifid), 1);
    chk("jmp_flush_idex", 32'(flush_idex), 1);
    tick();
    chk("jmp_fwda", 32'(ForwardA), FW_RF);
    chk("jmp_flush_cnt", 32'(flush_cnt), 1);
    chk("jmp_stall_cnt", 32'(stall_cnt), 1);
    jump = 1'b0;

    // reset asserted mid-stall
    set_id(1, 0, 0, 0, 0, 5'd2, 1, 1);
    tick();
    set_id(1, 5'd2, 1, 0, 0, 5'd13, 1, 0);
    #1 chk("mid_stall_pre", 32'(stall), 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_flush_idex", 32'(flush_idex), 0);
    chk("mid_rst_fwda", 32'(ForwardA), FW_RF);
    chk("mid_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("mid_rst_flush_cnt", 32'(flush_cnt), 0);
    #3 rstn = 1'b1;
    tick();
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("post_rst_flush_cnt", 32'(flush_cnt), 0);

    // flush counter saturation
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    jump = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("flush_cnt_sat", 32'(flush_cnt), 15);
    chk("flush_sat_stall_cnt", 32'(stall_cnt), 0);
    jump = 1'b0;

    // stall counter saturation: a load reading its own rd stalls every other cycle
    set_id(1, 5'd3, 1, 0, 0, 5'd3, 1, 1);
    for (int i = 0; i < 40; i++) tick();
    chk("stall_cnt_sat", 32'(stall_cnt), 15);
    chk("stall_sat_flush_cnt", 32'(flush_cnt), 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 Port: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-004 Port: id_valid  in  1  ID stage holds a real instruction.
REQ-005 Port: id_rs1, id_rs2  in  5 each  source register indices of the ID instruction.
REQ-006 Port: id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 or rs2.
REQ-007 Port: id_rd  in  5  destination register of the ID instruction.
REQ-008 Port: id_regwrite, id_memread  in  1 each  ID instruction writes rd, or is a load.
REQ-009 Port: jump  in  1  EX-stage redirect; NPC has selected a non-sequential PC this cycle.
REQ-010 Port: ForwardA, ForwardB  out  2 each  registered forwarding selects for the EX instruction: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
REQ-011 Port: stall  out  1  hold PC and IF/ID this cycle.
REQ-012 Port: flush_ifid, flush_idex  out  1 each  clear IF/ID or ID/EX at the next edge.
REQ-013 Port: stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-014 The unit SHALL keep a shadow entry per stage (EX, MEM, WB) of {valid, rd, regwrite, memread}, advancing ID->EX->MEM->WB every clock.
REQ-015 An entry SHALL be a "producer" only if valid=1, regwrite=1 and rd!=0.
REQ-016 Load-use hazard SHALL be: id_valid=1, EX entry is a producer with memread=1, and (id_use_rs1 and id_rs1==EX.rd) or (id_use_rs2 and id_rs2==EX.rd).
REQ-017 stall SHALL equal the load-use hazard AND NOT jump, combinationally.
REQ-018 flush_ifid SHALL equal jump; flush_idex SHALL equal jump OR stall.
REQ-019 On an edge with flush_idex=1, the new EX entry SHALL be a bubble (valid=0, regwrite=0, memread=0) and ForwardA/ForwardB SHALL load 00.
REQ-020 Otherwise the new EX entry SHALL capture id_* fields (valid=id_valid), and ForwardA SHALL load 10 if id_use_rs1 and the current EX entry is a producer with rd==id_rs1; else 01 if the current MEM entry is a producer with rd==id_rs1; else 00.
REQ-021 ForwardB SHALL follow REQ-020 using id_use_rs2/id_rs2.
REQ-022 EX/MEM match SHALL take priority over MEM/WB match for the same index.
REQ-023 Register x0 SHALL never be forwarded and SHALL never cause a stall.
REQ-024 Distance-3 dependences (WB entry) SHALL NOT be forwarded; the register file write-first path covers them.
REQ-025 Forward outputs SHALL have 1-cycle latency: values computed while the instruction is in ID are valid during its EX cycle.
REQ-026 After a one-cycle load-use stall, the retained ID instruction SHALL see the load in MEM and receive Forward=01.
REQ-027 Simultaneous jump and load-use: jump SHALL win; stall=0, both flushes=1, stall_cnt not incremented.
REQ-028 stall_cnt SHALL increment on each cycle with stall=1; flush_cnt on each cycle with jump=1; both SHALL saturate at all-ones.
REQ-029 The implementation SHALL be a single-clock design with no latches.

Reset
REQ-030 While rstn=0, all shadow entries SHALL be invalid, ForwardA=ForwardB=00, and counters 0.
REQ-031 stall, flush_ifid and flush_idex SHALL be 0 while rstn=0, regardless of inputs.
REQ-032 Reset asserted mid-stall SHALL discard the pending hazard; the first cycle after release SHALL show stall=0.

Verification
REQ-033 Back-to-back ALU: add x5 (regwrite) then ID reads rs1=x5 -> next cycle ForwardA=10, stall=0.
REQ-034 Distance 2: producer of x7, one independent instruction, then consumer of rs2=x7 -> ForwardB=01 in its EX cycle.
REQ-035 Load-use: lw x3, then ID reads rs1=x3 -> stall=1 and flush_idex=1 for exactly one cycle, then ForwardA=01, stall_cnt=1.
REQ-036 x0: producer with rd=0 followed by a reader of x0 -> Forward=00, no stall.
REQ-037 Jump with load-use present -> stall=0, flush_ifid=flush_idex=1, flush_cnt=1, stall_cnt=0; the next EX cycle shows Forward=00.
REQ-038 Assert rstn=0 during a stall cycle -> all outputs 0 immediately; after release with no hazard, stall=0 and counters stay 0.
